// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - single-port word RAM serving CPU instruction-fetch and data buses
// Data wins arbitration; a bounded data streak forces one fetch grant through.
module cpu_mem_responder #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int MAX_D_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W+1:0] i_addr,
   output logic              i_gnt,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_datain,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W+1:0] d_addr,
   input  logic [DATA_W-1:0] d_dataout,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_datain,
   output logic              d_err,
   output logic              i_err
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

   logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
   logic [3:0]        streak;
   logic              d_wins;
   logic [ADDR_W+1:0] acc_addr;
   logic [ADDR_W-1:0] acc_word;
   logic              acc_mis;
   logic [DATA_W-1:0] rd_word;

   // Data keeps the port until it has held it STREAK_MAX times against a waiting fetch.
   always_comb begin
      d_wins = d_req && (!i_req || (streak < STREAK_MAX));
      d_gnt  = reset_n && d_wins;
      i_gnt  = reset_n && i_req && !d_wins;
   end

   assign acc_addr = d_gnt ? d_addr : i_addr;
   assign acc_word = acc_addr[ADDR_W+1:2];
   assign acc_mis  = (acc_addr[1:0] != 2'b00);
   assign rd_word  = mem[acc_word];

   always_ff @(posedge clock) begin
      if (d_gnt && d_we && !acc_mis) begin
         mem[acc_word] <= d_dataout;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         streak   <= 4'd0;
         i_valid  <= 1'b0;
         i_err    <= 1'b0;
         i_datain <= '0;
         d_valid  <= 1'b0;
         d_err    <= 1'b0;
         d_datain <= '0;
      end else begin
         if (!i_req || i_gnt) begin
            streak <= 4'd0;
         end else if (d_gnt) begin
            streak <= streak + 4'd1;
         end

         i_valid <= i_gnt;
         i_err   <= i_gnt && acc_mis;
         if (i_gnt) begin
            i_datain <= acc_mis ? '0 : rd_word;
         end

         d_valid <= d_gnt;
         d_err   <= d_gnt && acc_mis;
         // A good store leaves d_datain alone; a misaligned access of either kind zeroes it.
         if (d_gnt && (acc_mis || !d_we)) begin
            d_datain <= acc_mis ? '0 : rd_word;
         end
      end
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the pipelined CPU's instruction-fetch and data buses. It produces the CPU's i_datain and d_datain words, and it consumes d_dataout store data.
- Single-port word RAM shared by both buses, one access per clock. Data has priority, with a bounded-starvation guarantee for instruction fetch.
- Replaces hand-driven instruction/data stimulus in CPU-level simulation. Also the RTL memory front-end.

Parameters:
- ADDR_W, 8, word-address width; RAM depth = 2**ADDR_W words.
- DATA_W, 32, word width.
- MAX_D_STREAK, 4, max consecutive data grants while i_req is pending before one instruction grant is forced (range 1..15).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction fetch request, level
- i_addr  in  ADDR_W+2  byte address of fetch
- i_gnt  out  1  combinational; fetch accepted at this edge
- i_valid  out  1  one-cycle pulse; i_datain valid
- i_datain  out  DATA_W  fetched instruction
- d_req  in  1  data request, level
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W+2  byte address of access
- d_dataout  in  DATA_W  store data from CPU
- d_gnt  out  1  combinational; data access accepted at this edge
- d_valid  out  1  one-cycle pulse; access complete
- d_datain  out  DATA_W  load data to CPU
- d_err  out  1  pulses with d_valid on a misaligned data access
- i_err  out  1  pulses with i_valid on a misaligned fetch

Behaviour:
- Reset: async assert forces i_valid, d_valid, i_err, d_err, i_datain, d_datain, the streak counter and the pending flags to 0. RAM contents are not reset. Gnt outputs are 0 while reset_n=0.
- Reset mid-access: the accepted-but-unanswered response is dropped; no valid pulse follows reset release.
- Handshake:
  - A request is accepted at the rising edge where req && gnt.
  - The response is valid exactly one cycle later, as a registered pulse on the *_valid output.
  - If req is still high after gnt, it is a NEW request and may be granted in the same cycle its predecessor's valid is high. Back-to-back gives 1 access/cycle.
- Arbitration, evaluated combinationally each cycle:
  - Only d_req: d_gnt=1.
  - Only i_req: i_gnt=1.
  - Both asserted, streak < MAX_D_STREAK: d_gnt=1, i_gnt=0.
  - Both asserted, streak == MAX_D_STREAK: i_gnt=1, d_gnt=0.
  - At most one gnt is ever high.
- Streak counter (4 bit):
  - +1 on each data grant while i_req=1.
  - Cleared on any instruction grant, or on any cycle with i_req=0.
  - Never exceeds MAX_D_STREAK.
- Addressing: word index = addr[ADDR_W+1:2]. addr[1:0] != 0 marks the access misaligned.
- Load: d_datain <= RAM[word] at the accept edge. d_valid=1 next cycle.
- Store: RAM[word] <= d_dataout at the accept edge. d_valid pulses next cycle, and d_datain holds its previous value.
- Fetch: i_datain <= RAM[word]. i_valid=1 next cycle.
- Misaligned access: still granted and answered. No RAM write. The data output is 0, and err=1 together with valid.
- Output hold: i_datain and d_datain hold their last value between valids.
- Read-after-write: a load of the same word granted one cycle after a store returns the new data. This falls out naturally because the store writes at its accept edge.
- No combinational path from req to valid. gnt depends only on req and the streak counter.

Test Plan:
- Reset: hold reset_n=0 with both reqs high -> gnt=0, valid=0, datain=0. Assert reset_n=0 mid-cycle right after a grant -> no valid after release.
- Store/load:
  - Store 0x0000_00AB to addr 0x004, then load addr 0x004 -> d_valid one cycle after each grant, load returns 0x0000_00AB.
  - Store 0x0000_3C00 to 0x008, then load 0x008 -> returns 0x0000_3C00.
- Unified fetch: store 0x8C01_0001 to 0x010 via the data port, then fetch i_addr=0x010 -> i_valid next cycle, i_datain=0x8C01_0001.
- Back-to-back fetch: i_req held high with addresses 0x000, 0x004, 0x008 on consecutive cycles -> i_gnt=1 every cycle, three consecutive i_valid pulses returning the stored words in order.
- Fairness: i_req and d_req both held high for 12 cycles, MAX_D_STREAK=4 -> grant pattern D,D,D,D,I repeating. i_gnt is high on cycles 5 and 10.
- Misaligned: load d_addr=0x006 -> d_valid=1, d_err=1, d_datain=0. Store to 0x005 -> d_err=1, and a subsequent load of 0x004 is unchanged.
